// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: deep streaming FIFO built on one 1rw1r SRAM macro.
// Writes go through rw0 (write-only). Reads are prefetched through r0 into a
// 2-entry output stage, which hides the macro's 1-cycle read latency and its
// X-on-idle read data behind a valid/ready interface.
// Optional feature: define SRAM_FIFO_LEVEL_EN to add a registered 'level' output.
module sram_fifo_ctrl #(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_data,
`ifdef SRAM_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH+1:0] level,
`endif
  output logic                  rw0_ce_in,
  output logic                  rw0_we_in,
  output logic [ADDR_WIDTH-1:0] rw0_addr_in,
  output logic [BITS-1:0]       rw0_wd_in,
  output logic                  r0_ce_in,
  output logic [ADDR_WIDTH-1:0] r0_addr_in,
  input  logic [BITS-1:0]       r0_rd_out
);

  localparam logic [ADDR_WIDTH:0] L_FULL = (ADDR_WIDTH+1)'(WORD_DEPTH);

  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [ADDR_WIDTH:0]   r_mem_count;
  logic                  r_rd_pend;
  logic [1:0]            r_os_cnt;
  logic [BITS-1:0]       r_os0, r_os1;

  logic                  w_push, w_pop, w_fetch;
  logic [2:0]            w_occ;
  logic [ADDR_WIDTH-1:0] w_wptr_nxt, w_rptr_nxt;
  logic [ADDR_WIDTH:0]   w_mem_count_nxt;
  logic                  w_rd_pend_nxt;
  logic [1:0]            w_os_cnt_nxt;
  logic [BITS-1:0]       w_os0_nxt, w_os1_nxt;

  assign in_ready  = (r_mem_count != L_FULL) && !clear;
  assign w_push    = in_valid && in_ready;
  assign out_valid = (r_os_cnt != 2'd0);
  assign w_pop     = out_valid && out_ready;
  // Output-stage slots that will be taken after this edge if no new fetch is issued.
  assign w_occ     = {1'b0, r_os_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  // mem_count is registered, so a word is fetchable only after its write edge;
  // rw0 and r0 therefore never touch the same word in one cycle.
  assign w_fetch   = !clear && (r_mem_count != '0) && (w_occ < 3'd2);

  // Enables are gated by rst_n so they drop without waiting for a clock edge.
  assign rw0_ce_in   = w_push && rst_n;
  assign rw0_we_in   = w_push && rst_n;
  assign rw0_addr_in = r_wptr;
  assign rw0_wd_in   = w_push ? in_data : '0;
  assign r0_ce_in    = w_fetch && rst_n;
  assign r0_addr_in  = r_rptr;
  assign out_data    = out_valid ? r_os0 : '0;

  // Next-state: pointers, SRAM occupancy and the skid buffer; clear overrides all.
  always_comb begin
    w_wptr_nxt      = r_wptr;
    w_rptr_nxt      = r_rptr;
    w_mem_count_nxt = r_mem_count;
    w_rd_pend_nxt   = w_fetch;
    w_os_cnt_nxt    = r_os_cnt;
    w_os0_nxt       = r_os0;
    w_os1_nxt       = r_os1;
    if (w_push) w_wptr_nxt = r_wptr + 1'b1;
    if (w_fetch) w_rptr_nxt = r_rptr + 1'b1;
    w_mem_count_nxt = r_mem_count + {{ADDR_WIDTH{1'b0}}, w_push}
                                  - {{ADDR_WIDTH{1'b0}}, w_fetch};
    // r0_rd_out is only looked at in the cycle after a fetch (r_rd_pend).
    case ({w_pop, r_rd_pend})
      2'b10: begin
        w_os0_nxt    = r_os1;
        w_os_cnt_nxt = r_os_cnt - 2'd1;
      end
      2'b01: begin
        if (r_os_cnt == 2'd0) w_os0_nxt = r_os_read();
        else                  w_os1_nxt = r_os_read();
        w_os_cnt_nxt = r_os_cnt + 2'd1;
      end
      2'b11: begin
        if (r_os_cnt == 2'd1) begin
          w_os0_nxt = r_os_read();
        end else begin
          w_os0_nxt = r_os1;
          w_os1_nxt = r_os_read();
        end
      end
      default: ;
    endcase
    if (clear) begin
      w_wptr_nxt      = '0;
      w_rptr_nxt      = '0;
      w_mem_count_nxt = '0;
      w_rd_pend_nxt   = 1'b0;
      w_os_cnt_nxt    = 2'd0;
      w_os0_nxt       = '0;
      w_os1_nxt       = '0;
    end
  end

  function automatic logic [BITS-1:0] r_os_read();
    return r0_rd_out;
  endfunction

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_mem_count <= '0;
      r_rd_pend   <= 1'b0;
      r_os_cnt    <= 2'd0;
      r_os0       <= '0;
      r_os1       <= '0;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_mem_count <= w_mem_count_nxt;
      r_rd_pend   <= w_rd_pend_nxt;
      r_os_cnt    <= w_os_cnt_nxt;
      r_os0       <= w_os0_nxt;
      r_os1       <= w_os1_nxt;
    end
  end

`ifdef SRAM_FIFO_LEVEL_EN
  logic [ADDR_WIDTH+1:0] r_level;
  logic [ADDR_WIDTH+1:0] w_level_nxt;

  assign w_level_nxt = {1'b0, w_mem_count_nxt}
                     + {{(ADDR_WIDTH+1){1'b0}}, w_rd_pend_nxt}
                     + {{ADDR_WIDTH{1'b0}}, w_os_cnt_nxt};
  assign level = r_level;

  // Registered fill level: tracks the total words held after each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level <= '0;
    else        r_level <= w_level_nxt;
  end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed self-checking bench for sram_fifo_ctrl with a
// behavioural model of the 1rw1r SRAM macro attached.
module tb_sram_fifo_ctrl;
  localparam int BITS = 64;
  localparam int WD   = 1024;
  localparam int AW   = 10;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic            clk = 1'b0;
  logic            rst_n, clear, in_valid, in_ready, out_valid, out_ready;
  logic [BITS-1:0] in_data, out_data;
  logic            rw0_ce_in, rw0_we_in, r0_ce_in;
  logic [AW-1:0]   rw0_addr_in, r0_addr_in;
  logic [BITS-1:0] rw0_wd_in, r0_rd_out;
`ifdef SRAM_FIFO_LEVEL_EN
  logic [AW+1:0]   level;
`endif

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.BITS(BITS), .WORD_DEPTH(WD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef SRAM_FIFO_LEVEL_EN
    .level(level),
`endif
    .rw0_ce_in(rw0_ce_in), .rw0_we_in(rw0_we_in), .rw0_addr_in(rw0_addr_in),
    .rw0_wd_in(rw0_wd_in), .r0_ce_in(r0_ce_in), .r0_addr_in(r0_addr_in),
    .r0_rd_out(r0_rd_out)
  );

  // SRAM model: read-first, and junk on r0 whenever the read port was idle.
  logic [BITS-1:0] mem [WD];
  always @(posedge clk) begin
    if (rw0_ce_in && rw0_we_in) mem[rw0_addr_in] <= rw0_wd_in;
    r0_rd_out <= r0_ce_in ? mem[r0_addr_in] : JUNK;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n words through a queue scoreboard; rnd randomises both handshakes.
  task automatic run_stream(input string tag, input int n, input bit rnd);
    logic [63:0] q[$];
    int sent = 0, got = 0, errs = 0, gaps = 0, coll = 0, wraps = 0, cyc = 0;
    bit started = 0;
    while (got < n && cyc < 20000) begin
      in_valid  = (sent < n) && (!rnd || $urandom_range(0, 1) == 1);
      in_data   = 64'(sent) * 64'h9E37_79B9_7F4A_7C15 + 64'(n);
      out_ready = !rnd || $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (rw0_ce_in && r0_ce_in && rw0_addr_in == r0_addr_in) coll++;
      if (rw0_ce_in && rw0_addr_in == AW'(WD - 1)) wraps++;
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      if (out_valid) started = 1;
      else if (started && sent < n) gaps++;
      if (out_valid && out_ready) begin
        if (q.size() == 0 || out_data !== q[0]) errs++;
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_count"}, 64'(got), 64'(n));
    chk({tag, "_data_errs"}, 64'(errs), 64'd0);
    chk({tag, "_addr_collisions"}, 64'(coll), 64'd0);
    if (!rnd) begin
      chk({tag, "_gaps"}, 64'(gaps), 64'd0);
      chk({tag, "_wrap_ge2"}, 64'(wraps >= 2), 64'd1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc, exp_v, errs, seen;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b0;

    // Reset: enables gated even with in_valid high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_rw0_ce", 64'(rw0_ce_in), 64'd0);
    chk("rst_r0_ce", 64'(r0_ce_in), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Single word: 2-cycle latency.
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001; out_ready = 1'b1;
    @(negedge clk);
    chk("t1_rw0_ce", 64'(rw0_ce_in), 64'd1);
    chk("t1_rw0_addr", 64'(rw0_addr_in), 64'd0);
    chk("t1_rw0_wd", rw0_wd_in, 64'hDEAD_BEEF_0000_0001);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_r0_ce", 64'(r0_ce_in), 64'd1);
    chk("t1_r0_addr", 64'(r0_addr_in), 64'd0);
    chk("t1_ov_c1", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_ov_c2", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_ov_c3", 64'(out_valid), 64'd1);
    chk("t1_data", out_data, 64'hDEAD_BEEF_0000_0001);
    tick();
    @(negedge clk);
    chk("t1_ov_after", 64'(out_valid), 64'd0);
    tick();

    // Fill to capacity with consumer stalled.
    out_ready = 1'b0; acc = 0;
    for (cyc = 0; cyc < 1100 && acc < 1026; cyc++) begin
      in_valid = 1'b1; in_data = 64'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    in_data = 64'd9999;
    @(negedge clk);
    chk("t2_accepted", 64'(acc), 64'd1026);
    chk("t2_no_stall", 64'(cyc), 64'd1026);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    chk("t2_head_valid", 64'(out_valid), 64'd1);
    chk("t2_head_data", out_data, 64'd0);
`ifdef SRAM_FIFO_LEVEL_EN
    chk("t2_level", 64'(level), 64'd1026);
`endif
    tick();
    in_valid = 1'b0; out_ready = 1'b1; exp_v = 0; errs = 0;
    for (cyc = 0; cyc < 1200 && exp_v < 1026; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (out_data !== 64'(exp_v)) errs++;
        exp_v++;
      end
      tick();
    end
    @(negedge clk);
    chk("t2_drain_count", 64'(exp_v), 64'd1026);
    chk("t2_drain_errs", 64'(errs), 64'd0);
    chk("t2_empty", 64'(out_valid), 64'd0);
    tick();

    // Continuous and random-handshake streaming.
    run_stream("t3_stream", 3000, 1'b0);
    run_stream("t4_random", 1000, 1'b1);

    // Clear with one word staged, one read in flight and one in SRAM.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA1; tick();
    in_data = 64'hB2; tick();
    in_data = 64'hC3; tick();
    clear = 1'b1; in_data = 64'hEE;
    @(negedge clk);
    chk("t5_pre_valid", 64'(out_valid), 64'd1);
    chk("t5_pre_data", out_data, 64'hA1);
    chk("t5_clr_ready", 64'(in_ready), 64'd0);
    chk("t5_clr_rw0_ce", 64'(rw0_ce_in), 64'd0);
    chk("t5_clr_r0_ce", 64'(r0_ce_in), 64'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_post_valid", 64'(out_valid), 64'd0);
    chk("t5_post_ready", 64'(in_ready), 64'd1);
    chk("t5_post_r0_ce", 64'(r0_ce_in), 64'd0);
`ifdef SRAM_FIFO_LEVEL_EN
    chk("t5_level", 64'(level), 64'd0);
`endif
    tick();
    in_valid = 1'b1; in_data = 64'h5; out_ready = 1'b1; tick();
    in_valid = 1'b0; seen = 0;
    for (cyc = 0; cyc < 10 && seen == 0; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        chk("t5_first_pop", out_data, 64'h5);
      end
      tick();
    end
    chk("t5_seen", 64'(seen), 64'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
      tick();
    end
    chk("t5_no_stale", 64'(seen), 64'd0);

    // Asynchronous reset mid-stream.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 64'(i) + 64'h100;
      tick();
    end
    @(negedge clk);
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_rw0_ce", 64'(rw0_ce_in), 64'd0);
    chk("t6_async_r0_ce", 64'(r0_ce_in), 64'd0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t6_ready", 64'(in_ready), 64'd1);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_rw0_addr", 64'(rw0_addr_in), 64'd0);
    chk("t6_r0_addr", 64'(r0_addr_in), 64'd0);
    chk("t6_known", 64'($isunknown({rw0_addr_in, r0_addr_in, rw0_we_in, rw0_wd_in,
                                     rw0_ce_in, r0_ce_in})), 64'd0);
    tick();
    in_valid = 1'b1; in_data = 64'h77; out_ready = 1'b1; tick();
    in_valid = 1'b0; tick();
    @(negedge clk);
    chk("t6_ov_c2", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("t6_ov_c3", 64'(out_valid), 64'd1);
    chk("t6_data", out_data, 64'h77);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- FIFO controller that turns one fakeram_1rw1r_64w1024d_sram macro into a deep streaming FIFO for the liteeth datapath.
- Sits directly upstream of the SRAM:
  - writes go through the rw0 port (write-only use);
  - reads are prefetched through the r0 port into a 2-entry output stage.
- Hides the macro's 1-cycle read latency and its X-on-idle read output behind a valid/ready stream interface.

Parameters:
- BITS, 64, data word width; must match the macro.
- WORD_DEPTH, 1024, SRAM words; power of two.
- ADDR_WIDTH, 10, log2(WORD_DEPTH).

Ports:
- clk  input  1  single clock; drives the macro's r0_clk and rw0_clk externally.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; discards all contents.
- in_valid  input  1  write-side data valid.
- in_ready  output  1  write side can accept data.
- in_data  input  BITS  write data.
- out_valid  output  1  read-side head word valid.
- out_ready  input  1  consumer accepts the head word.
- out_data  output  BITS  head word.
- rw0_ce_in  output  1  to macro rw0 chip enable.
- rw0_we_in  output  1  to macro rw0 write enable.
- rw0_addr_in  output  ADDR_WIDTH  to macro rw0 address.
- rw0_wd_in  output  BITS  to macro rw0 write data.
- r0_ce_in  output  1  to macro r0 chip enable.
- r0_addr_in  output  ADDR_WIDTH  to macro r0 address.
- r0_rd_out  input  BITS  from macro r0 read data.

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- State:
  - wptr, rptr: ADDR_WIDTH bits, wrap modulo WORD_DEPTH;
  - mem_count: 0..WORD_DEPTH, committed words not yet fetched;
  - rd_pend: 1 bit, r0 read issued last cycle;
  - ostage: 2-entry skid buffer, occupancy 0..2.
- Reset (async, rst_n low):
  - all pointers, counts, rd_pend and ostage cleared;
  - out_valid=0, out_data=0;
  - rw0_ce_in=0, r0_ce_in=0 (gated combinationally while rst_n low);
  - in_ready=1 immediately after release.
- Push:
  - in_ready = (mem_count != WORD_DEPTH) && !clear.
  - On push (in_valid && in_ready): rw0_ce_in=1, rw0_we_in=1, rw0_addr_in=wptr, rw0_wd_in=in_data in the same cycle; wptr++ and mem_count++ at the edge.
  - Otherwise rw0_ce_in=0, rw0_we_in=0.
- Fetch:
  - Issued when mem_count > 0 and (ostage occupancy + rd_pend − pop this cycle) < 2.
  - On fetch: r0_ce_in=1, r0_addr_in=rptr; rptr++, mem_count−−, rd_pend=1 at the edge.
  - The following cycle, r0_rd_out is written into ostage.
  - r0_rd_out is sampled only in that capture cycle, never otherwise, because it is X when r0_ce_in was low.
- Read-first hazard:
  - A word becomes fetchable only the cycle after its write edge, so a same-address read/write collision cannot occur.
- Latency:
  - Word accepted at edge N → r0 read at cycle N+1 → out_valid high after edge N+2 (2 cycles), when downstream is empty.
- Simultaneous push and fetch: mem_count unchanged; wptr and rptr both advance.
- Pop:
  - out_valid = ostage non-empty; out_data = ostage head.
  - On out_valid && out_ready the head is dropped.
  - Sustained throughput is 1 word/cycle with out_ready held high.
- Capacity:
  - total = WORD_DEPTH + 2 words.
  - in_ready deasserts only when the SRAM holds WORD_DEPTH unfetched words.
- Wrap-around:
  - pointer 1023 → 0;
  - full vs empty is distinguished by mem_count, not by pointer equality.
- clear (synchronous, highest priority over push and pop):
  - next edge: pointers, mem_count, ostage and rd_pend zeroed;
  - an in-flight read's data is discarded;
  - in_ready=0 during the clear cycle;
  - no SRAM enables are asserted in the clear cycle.
- X hygiene:
  - rw0_addr_in, r0_addr_in, rw0_we_in and rw0_wd_in are always known values after reset (hold the last value or 0 when idle);
  - this prevents the macro's corrupt-on-X path.

Optional Feature:
- Macro: SRAM_FIFO_LEVEL_EN.
- Defined:
  - adds output port level [ADDR_WIDTH+1:0];
  - level = mem_count + rd_pend + ostage occupancy, registered, updated every edge;
  - reset and clear value is 0;
  - maximum value WORD_DEPTH+2.
- Undefined: port absent, no extra logic.

Test Plan:
- Reset release, push one word 64'hDEAD_BEEF_0000_0001 with out_ready=1 → r0_ce_in high the cycle after the write; out_valid high exactly 2 cycles after acceptance; out_data matches; then out_valid=0.
- Push 1026 words (values 0..1025) with out_ready=0 → in_ready drops after word 1025 is accepted (1024 in SRAM + 2 in ostage); level=1026 with SRAM_FIFO_LEVEL_EN; pop all → data 0..1025 in order.
- Continuous stream of 3000 words with in_valid=out_ready=1 → pointers wrap past 1023 → 0 at least twice; no gaps after the 2-cycle fill latency; data in order; rw0 and r0 never both address the same word in one cycle.
- Random out_ready (50%) during streaming → no loss or duplication; a word is only ever read from r0_rd_out in the cycle after r0_ce_in=1.
- Assert clear while a read is pending and ostage holds 1 word → next cycle out_valid=0, in_ready=1, level=0; the next pushed word 64'h5 is the first popped.
- Assert rst_n low mid-stream asynchronously → out_valid, rw0_ce_in and r0_ce_in go 0 without a clock edge; after release the FIFO is empty and all SRAM address and control outputs are non-X.
